// File: rtl/vscale_mp_hasti_sram_pkg.sv
// Shared encodings for the multi-port HASTI SRAM: transfer/response codes,
// per-port state encoding, write-broadcast payload and byte-mask helpers.
package vscale_mp_hasti_sram_pkg;

  localparam logic [1:0] HASTI_TRANS_NONSEQ = 2'b10;

  localparam logic HASTI_RESP_OKAY  = 1'b0;
  localparam logic HASTI_RESP_ERROR = 1'b1;

  localparam logic [2:0] HASTI_SIZE_BYTE = 3'd0;
  localparam logic [2:0] HASTI_SIZE_HALF = 3'd1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  // p0 write data phase as seen by every port for bypass
  typedef struct packed {
    logic        commit;
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_bcast_t;

  function automatic logic [3:0] byte_mask(input logic [2:0] hsize, input logic [1:0] off);
    logic [3:0] base;
    case (hsize)
      HASTI_SIZE_BYTE: base = 4'h1;
      HASTI_SIZE_HALF: base = 4'h3;
      default:         base = 4'hF;
    endcase
    return 4'(base << off);
  endfunction

  function automatic logic [31:0] expand_mask(input logic [3:0] m);
    logic [31:0] bits;
    bits = '0;
    for (int b = 0; b < 4; b++) bits[8*b +: 8] = {8{m[b]}};
    return bits;
  endfunction

endpackage

// File: rtl/vscale_mp_hasti_sram_if.sv
// HASTI bus bundle for the multi-port SRAM: one read/write port (p0) and
// NUM_RD read-only ports (pr) packed 32/2/1 bits per port.
interface vscale_mp_hasti_sram_if #(
  parameter int unsigned NUM_RD = 2
);
  logic [31:0]          p0_haddr;
  logic                 p0_hwrite;
  logic [2:0]           p0_hsize;
  logic [2:0]           p0_hburst;
  logic                 p0_hmastlock;
  logic [3:0]           p0_hprot;
  logic [1:0]           p0_htrans;
  logic [31:0]          p0_hwdata;
  logic [31:0]          p0_hrdata;
  logic                 p0_hready;
  logic                 p0_hresp;

  logic [NUM_RD*32-1:0] pr_haddr;
  logic [NUM_RD*2-1:0]  pr_htrans;
  logic [NUM_RD-1:0]    pr_hwrite;
  logic [NUM_RD*32-1:0] pr_hrdata;
  logic [NUM_RD-1:0]    pr_hready;
  logic [NUM_RD-1:0]    pr_hresp;

  modport master (
    output p0_haddr, p0_hwrite, p0_hsize, p0_hburst, p0_hmastlock, p0_hprot,
           p0_htrans, p0_hwdata, pr_haddr, pr_htrans, pr_hwrite,
    input  p0_hrdata, p0_hready, p0_hresp, pr_hrdata, pr_hready, pr_hresp
  );

  modport slave (
    input  p0_haddr, p0_hwrite, p0_hsize, p0_hburst, p0_hmastlock, p0_hprot,
           p0_htrans, p0_hwdata, pr_haddr, pr_htrans, pr_hwrite,
    output p0_hrdata, p0_hready, p0_hresp, pr_hrdata, pr_hready, pr_hresp
  );
endinterface

// File: rtl/vscale_mp_hasti_sram_rport.sv
// One HASTI port: transfer FSM with two-cycle error response, range check,
// array read request and the byte-masked bypass merge of a same-cycle write.
module vscale_mp_hasti_sram_rport
  import vscale_mp_hasti_sram_pkg::*;
#(
  parameter int unsigned NWORDS   = 32,
  parameter int unsigned IDX_W    = 5,
  parameter bit          ALLOW_WR = 1'b0
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic [29:0]      waddr,
  input  logic [1:0]       htrans,
  input  logic             hwrite,
  input  logic [IDX_W-1:0] wr_idx,
  input  wr_bcast_t        wr_bus,
  input  logic [31:0]      array_q,
  output logic             accept_c,
  output logic             rd_en_c,
  output logic [IDX_W-1:0] rd_idx_c,
  output logic [31:0]      hrdata,
  output logic             hready,
  output logic             hresp
);

  logic [1:0]  state_q, state_nxt;
  logic        rd_q, rd_nxt;
  logic        hready_nxt, hresp_nxt;
  logic [3:0]  byp_mask_q;
  logic [31:0] byp_data_q;
  logic [31:0] hold_q;
  logic [31:0] byp_bits_c;
  logic [31:0] merged_c;
  logic        in_range_c;
  logic        bad_c;
  logic        data_rd_c;

  assign in_range_c = (waddr < 30'(NWORDS));
  assign bad_c      = !in_range_c || (hwrite && !ALLOW_WR);
  assign rd_idx_c   = waddr[IDX_W-1:0];

  // Next state; ERR1 swallows the offered address phase
  always_comb begin
    state_nxt  = ST_IDLE;
    rd_nxt     = 1'b0;
    accept_c   = 1'b0;
    rd_en_c    = 1'b0;
    if (state_q == ST_ERR1) begin
      state_nxt = ST_ERR2;
    end else if (htrans == HASTI_TRANS_NONSEQ) begin
      if (bad_c) begin
        state_nxt = ST_ERR1;
      end else begin
        state_nxt = ST_DATA;
        accept_c  = 1'b1;
        rd_nxt    = !hwrite;
        rd_en_c   = !hwrite;
      end
    end
    hready_nxt = (state_nxt != ST_ERR1);
    hresp_nxt  = ((state_nxt == ST_ERR1) || (state_nxt == ST_ERR2)) ? HASTI_RESP_ERROR
                                                                     : HASTI_RESP_OKAY;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= ST_IDLE;
      rd_q       <= 1'b0;
      hready     <= 1'b1;
      hresp      <= HASTI_RESP_OKAY;
      byp_mask_q <= 4'h0;
      byp_data_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q <= state_nxt;
      rd_q    <= rd_nxt;
      hready  <= hready_nxt;
      hresp   <= hresp_nxt;
      if (rd_en_c) begin
        byp_mask_q <= (wr_bus.commit && (wr_idx == rd_idx_c)) ? wr_bus.mask : 4'h0;
        byp_data_q <= wr_bus.data;
      end
      if (data_rd_c) hold_q <= merged_c;
    end
  end

  // Array word overlaid with the lanes written while the read was in flight
  assign data_rd_c  = (state_q == ST_DATA) && rd_q;
  assign byp_bits_c = expand_mask(byp_mask_q);
  assign merged_c   = (array_q & ~byp_bits_c) | (byp_data_q & byp_bits_c);
  assign hrdata     = data_rd_c ? merged_c : hold_q;

endmodule

// File: rtl/vscale_mp_hasti_sram.sv
// Multi-port HASTI SRAM: synchronous-read array, p0 byte-masked write pipeline
// and a write broadcast that lets every port bypass a same-cycle commit.
module vscale_mp_hasti_sram
  import vscale_mp_hasti_sram_pkg::*;
#(
  parameter int unsigned NWORDS = 32,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  vscale_mp_hasti_sram_if.slave    bus
);

  localparam int unsigned IDX_W = $clog2(NWORDS);
  localparam int unsigned NPORT = NUM_RD + 1;

  logic [31:0]      mem [NWORDS];

  logic [29:0]      port_waddr  [NPORT];
  logic [1:0]       port_htrans [NPORT];
  logic             port_hwrite [NPORT];
  logic             accept_c    [NPORT];
  logic             rd_en_c     [NPORT];
  logic [IDX_W-1:0] rd_idx_c    [NPORT];
  logic [31:0]      array_q     [NPORT];
  logic [31:0]      port_hrdata [NPORT];
  logic             port_hready [NPORT];
  logic             port_hresp  [NPORT];

  logic [NUM_RD*32-1:0] pr_hrdata_c;
  logic [NUM_RD-1:0]    pr_hready_c;
  logic [NUM_RD-1:0]    pr_hresp_c;
  logic [NUM_RD*2-1:0]  unused_pr_lsb;
  logic                 unused_ok;

  logic             wr_pend_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [3:0]       wr_mask_q;
  logic [31:0]      wr_bits_c;
  wr_bcast_t        wr_bus_c;

  assign port_waddr[0]  = bus.p0_haddr[31:2];
  assign port_htrans[0] = bus.p0_htrans;
  assign port_hwrite[0] = bus.p0_hwrite;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_pr_map
    assign port_waddr[k+1]          = bus.pr_haddr[32*k+2 +: 30];
    assign port_htrans[k+1]         = bus.pr_htrans[2*k +: 2];
    assign port_hwrite[k+1]         = bus.pr_hwrite[k];
    assign unused_pr_lsb[2*k +: 2]  = bus.pr_haddr[32*k +: 2];
    assign pr_hrdata_c[32*k +: 32]  = port_hrdata[k+1];
    assign pr_hready_c[k]           = port_hready[k+1];
    assign pr_hresp_c[k]            = port_hresp[k+1];
  end

  assign bus.p0_hrdata = port_hrdata[0];
  assign bus.p0_hready = port_hready[0];
  assign bus.p0_hresp  = port_hresp[0];
  assign bus.pr_hrdata = pr_hrdata_c;
  assign bus.pr_hready = pr_hready_c;
  assign bus.pr_hresp  = pr_hresp_c;

  assign unused_ok = ^{bus.p0_hburst, bus.p0_hmastlock, bus.p0_hprot, unused_pr_lsb};

  always_comb begin
    wr_bus_c        = '0;
    wr_bus_c.commit = wr_pend_q;
    wr_bus_c.mask   = wr_mask_q;
    wr_bus_c.data   = bus.p0_hwdata;
  end

  for (genvar g = 0; g < NPORT; g++) begin : g_port
    vscale_mp_hasti_sram_rport #(
      .NWORDS   (NWORDS),
      .IDX_W    (IDX_W),
      .ALLOW_WR (g == 0)
    ) u_port (
      .hclk     (hclk),
      .hresetn  (hresetn),
      .waddr    (port_waddr[g]),
      .htrans   (port_htrans[g]),
      .hwrite   (port_hwrite[g]),
      .wr_idx   (wr_idx_q),
      .wr_bus   (wr_bus_c),
      .array_q  (array_q[g]),
      .accept_c (accept_c[g]),
      .rd_en_c  (rd_en_c[g]),
      .rd_idx_c (rd_idx_c[g]),
      .hrdata   (port_hrdata[g]),
      .hready   (port_hready[g]),
      .hresp    (port_hresp[g])
    );
  end

  // p0 write address phase: capture target word and lane mask for the data phase
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wr_pend_q <= 1'b0;
      wr_idx_q  <= '0;
      wr_mask_q <= 4'h0;
    end else begin
      wr_pend_q <= accept_c[0] && bus.p0_hwrite;
      if (accept_c[0] && bus.p0_hwrite) begin
        wr_idx_q  <= bus.p0_haddr[IDX_W+1:2];
        wr_mask_q <= byte_mask(bus.p0_hsize, bus.p0_haddr[1:0]);
      end
    end
  end

  assign wr_bits_c = expand_mask(wr_mask_q);

  always_ff @(posedge hclk) begin
    if (wr_pend_q) mem[wr_idx_q] <= (mem[wr_idx_q] & ~wr_bits_c) | (bus.p0_hwdata & wr_bits_c);
  end

  // One synchronous read port per HASTI port
  always_ff @(posedge hclk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (rd_en_c[p]) array_q[p] <= mem[rd_idx_c[p]];
    end
  end

endmodule

// File: tb/tb_vscale_mp_hasti_sram.sv
// Bench for vscale_mp_hasti_sram: directed scenarios plus random traffic on all
// ports, checked every cycle against a transaction-level memory model.
module tb_vscale_mp_hasti_sram;

  localparam int unsigned NWORDS = 32;
  localparam int unsigned NUM_RD = 2;
  localparam int unsigned NPORT  = NUM_RD + 1;
  localparam int unsigned IW     = $clog2(NWORDS);

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  vscale_mp_hasti_sram_if #(.NUM_RD(NUM_RD)) bus ();

  vscale_mp_hasti_sram #(.NWORDS(NWORDS), .NUM_RD(NUM_RD)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  // Model: memory image, pending p0 write, per-port error stage and expected outputs
  logic [31:0]   mmem [NWORDS];
  logic          wp_valid;
  logic [IW-1:0] wp_word;
  logic [31:0]   wp_mask;
  bit            err1      [NPORT];
  logic [31:0]   exp_rdata [NPORT];
  logic          exp_ready [NPORT];
  logic          exp_resp  [NPORT];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
    logic [31:0] m;
    int nbytes;
    m = '0;
    nbytes = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
    for (int b = 0; b < 4; b++)
      if (b >= int'(off) && b < int'(off) + nbytes) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] port_addr(input int p);
    if (p == 0) return bus.p0_haddr;
    return bus.pr_haddr[32*(p-1) +: 32];
  endfunction

  function automatic logic [1:0] port_trans(input int p);
    if (p == 0) return bus.p0_htrans;
    return bus.pr_htrans[2*(p-1) +: 2];
  endfunction

  function automatic logic port_write(input int p);
    if (p == 0) return bus.p0_hwrite;
    return bus.pr_hwrite[p-1];
  endfunction

  function automatic logic [31:0] port_rdata(input int p);
    if (p == 0) return bus.p0_hrdata;
    return bus.pr_hrdata[32*(p-1) +: 32];
  endfunction

  function automatic logic port_ready(input int p);
    if (p == 0) return bus.p0_hready;
    return bus.pr_hready[p-1];
  endfunction

  function automatic logic port_resp(input int p);
    if (p == 0) return bus.p0_hresp;
    return bus.pr_hresp[p-1];
  endfunction

  task automatic model_reset();
    wp_valid = 1'b0;
    wp_word  = '0;
    wp_mask  = '0;
    for (int p = 0; p < NPORT; p++) begin
      err1[p] = 1'b0; exp_rdata[p] = '0; exp_ready[p] = 1'b1; exp_resp[p] = 1'b0;
    end
  endtask

  task automatic check_ports(input string tag);
    for (int p = 0; p < NPORT; p++) begin
      check_eq($sformatf("%s_p%0d_hrdata", tag, p), port_rdata(p), exp_rdata[p]);
      check_eq($sformatf("%s_p%0d_hready", tag, p), 32'(port_ready(p)), 32'(exp_ready[p]));
      check_eq($sformatf("%s_p%0d_hresp", tag, p), 32'(port_resp(p)), 32'(exp_resp[p]));
    end
  endtask

  // Apply the currently driven cycle to the model, clock it, compare all ports
  task automatic step();
    logic [31:0]   a;
    int unsigned   w;
    bit            nwp;
    logic [IW-1:0] nword;
    logic [31:0]   nmask;
    nwp = 1'b0; nword = '0; nmask = '0;
    if (wp_valid) mmem[wp_word] = (mmem[wp_word] & ~wp_mask) | (bus.p0_hwdata & wp_mask);
    for (int p = 0; p < NPORT; p++) begin
      a = port_addr(p);
      w = 32'(a[31:2]);
      if (err1[p]) begin
        err1[p] = 1'b0; exp_ready[p] = 1'b1; exp_resp[p] = 1'b1;
      end else if (port_trans(p) == 2'b10) begin
        if (w >= NWORDS || (p != 0 && port_write(p))) begin
          err1[p] = 1'b1; exp_ready[p] = 1'b0; exp_resp[p] = 1'b1;
        end else begin
          exp_ready[p] = 1'b1; exp_resp[p] = 1'b0;
          if (!port_write(p)) exp_rdata[p] = mmem[IW'(w)];
          else begin
            nwp = 1'b1; nword = IW'(w); nmask = lane_mask(bus.p0_hsize, a[1:0]);
          end
        end
      end else begin
        exp_ready[p] = 1'b1; exp_resp[p] = 1'b0;
      end
    end
    wp_valid = nwp; wp_word = nword; wp_mask = nmask;
    @(posedge hclk); #1;
    check_ports("cyc");
  endtask

  task automatic idle_all();
    bus.p0_htrans = 2'b00;
    bus.p0_hwrite = 1'b0;
    bus.pr_htrans = '0;
    bus.pr_hwrite = '0;
  endtask

  task automatic p0_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    bus.p0_htrans = 2'b10; bus.p0_hwrite = wr; bus.p0_haddr = addr; bus.p0_hsize = size;
  endtask

  task automatic pr_xfer(input int k, input logic wr, input logic [31:0] addr);
    bus.pr_htrans[2*k +: 2] = 2'b10; bus.pr_hwrite[k] = wr; bus.pr_haddr[32*k +: 32] = addr;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    idle_all(); p0_xfer(1'b1, addr, 3'd2); step();
    idle_all(); bus.p0_hwdata = data; step();
  endtask

  initial begin
    logic [31:0] old;
    logic [31:0] addr;
    int unsigned word;
    logic [2:0]  size;
    logic [1:0]  off;

    idle_all();
    bus.p0_haddr = '0; bus.p0_hsize = 3'd2; bus.p0_hwdata = '0;
    bus.p0_hburst = '0; bus.p0_hmastlock = 1'b0; bus.p0_hprot = '0;
    bus.pr_haddr = '0;
    model_reset();

    hresetn = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    check_ports("reset");
    hresetn = 1'b1;

    for (int i = 0; i < int'(NWORDS); i++) write_word(32'(i * 4), $urandom);

    // Word write then read two cycles after the address phase
    write_word(32'h10, 32'hDEADBEEF);
    idle_all(); p0_xfer(1'b0, 32'h10, 3'd2); pr_xfer(0, 1'b0, 32'h10); step();
    check_eq("word_wr_p0", bus.p0_hrdata, 32'hDEADBEEF);
    check_eq("word_wr_pr0", bus.pr_hrdata[31:0], 32'hDEADBEEF);
    check_eq("word_wr_resp", 32'(bus.p0_hresp), 32'd0);

    // Byte write with both read ports reading during its data phase
    write_word(32'h10, 32'h11223344);
    idle_all(); p0_xfer(1'b1, 32'h12, 3'd0); step();
    idle_all(); bus.p0_hwdata = 32'hFFAAFFFF;
    pr_xfer(0, 1'b0, 32'h10); pr_xfer(1, 1'b0, 32'h10); step();
    check_eq("bypass_pr0", bus.pr_hrdata[31:0], 32'h11AA3344);
    check_eq("bypass_pr1", bus.pr_hrdata[63:32], 32'h11AA3344);

    // Half write to the upper half of word 3
    write_word(32'h0C, 32'h12345678);
    idle_all(); p0_xfer(1'b1, 32'h0E, 3'd1); step();
    idle_all(); bus.p0_hwdata = 32'hBEEF0000; step();
    idle_all(); p0_xfer(1'b0, 32'h0C, 3'd2); step();
    check_eq("half_wr", bus.p0_hrdata, 32'hBEEF5678);

    // Out-of-range read: ERR1, ERR2 (offered address ignored), then a clean read
    idle_all(); p0_xfer(1'b0, 32'h80, 3'd2); step();
    check_eq("oor_err1_ready", 32'(bus.p0_hready), 32'd0);
    check_eq("oor_err1_resp", 32'(bus.p0_hresp), 32'd1);
    p0_xfer(1'b0, 32'h10, 3'd2); step();
    check_eq("oor_err2_ready", 32'(bus.p0_hready), 32'd1);
    check_eq("oor_err2_resp", 32'(bus.p0_hresp), 32'd1);
    check_eq("oor_err2_hold", bus.p0_hrdata, 32'hBEEF5678);
    p0_xfer(1'b0, 32'h10, 3'd2); step();
    check_eq("oor_after_resp", 32'(bus.p0_hresp), 32'd0);
    check_eq("oor_after_data", bus.p0_hrdata, 32'h11AA3344);

    // Write attempt on a read-only port
    idle_all(); pr_xfer(1, 1'b1, 32'h10); step();
    check_eq("prwr_err1_ready", 32'(bus.pr_hready[1]), 32'd0);
    check_eq("prwr_err1_resp", 32'(bus.pr_hresp[1]), 32'd1);
    idle_all(); bus.p0_hwdata = 32'h0BADF00D; step();
    check_eq("prwr_err2_resp", 32'(bus.pr_hresp[1]), 32'd1);

    // Out-of-range p0 write must not land anywhere (e.g. aliased onto word 0)
    idle_all(); p0_xfer(1'b1, 32'h80, 3'd2); step();
    check_eq("oorwr_err1_resp", 32'(bus.p0_hresp), 32'd1);
    idle_all(); bus.p0_hwdata = 32'h0BADF00D; step();
    idle_all(); p0_xfer(1'b0, 32'h10, 3'd2); pr_xfer(0, 1'b0, 32'h0); step();
    check_eq("oorwr_word4", bus.p0_hrdata, 32'h11AA3344);

    // Reset during a write data phase drops the write, outputs clear at once
    idle_all(); p0_xfer(1'b0, 32'h14, 3'd2); step();
    idle_all(); p0_xfer(1'b1, 32'h04, 3'd2); pr_xfer(0, 1'b0, 32'h200); step();
    old = mmem[1];
    idle_all(); bus.p0_hwdata = ~old;
    #2 hresetn = 1'b0;
    #1;
    check_eq("rst_p0_hrdata", bus.p0_hrdata, 32'h0);
    check_eq("rst_p0_hready", 32'(bus.p0_hready), 32'd1);
    check_eq("rst_pr0_hready", 32'(bus.pr_hready[0]), 32'd1);
    check_eq("rst_pr0_hresp", 32'(bus.pr_hresp[0]), 32'd0);
    model_reset();
    @(posedge hclk); #1;
    hresetn = 1'b1;
    idle_all(); p0_xfer(1'b0, 32'h04, 3'd2); step();
    check_eq("rst_keep_word1", bus.p0_hrdata, old);

    // Random traffic on all ports, hot words favoured to provoke bypass
    repeat (3000) begin
      bus.p0_hwdata = $urandom;
      for (int p = 0; p < int'(NPORT); p++) begin
        logic [1:0] tr;
        logic       wr;
        tr   = ($urandom_range(0, 9) < 6) ? 2'b10 : 2'($urandom_range(0, 3));
        word = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, NWORDS - 1);
        size = 3'($urandom_range(0, 2));
        off  = (size == 3'd0) ? 2'($urandom_range(0, 3)) : (size == 3'd1) ? 2'(2 * $urandom_range(0, 1)) : 2'd0;
        addr = 32'(word * 4) + 32'(off);
        if ($urandom_range(0, 7) == 0)
          addr = ($urandom_range(0, 1) == 0) ? 32'(NWORDS * 4 + 4 * $urandom_range(0, 255)) : ($urandom & ~32'h3);
        if (p == 0) begin
          wr = 1'($urandom_range(0, 1));
          bus.p0_htrans = tr; bus.p0_hwrite = wr; bus.p0_haddr = addr; bus.p0_hsize = size;
        end else begin
          wr = ($urandom_range(0, 19) == 0);
          bus.pr_htrans[2*(p-1) +: 2] = tr;
          bus.pr_hwrite[p-1] = wr;
          bus.pr_haddr[32*(p-1) +: 32] = addr;
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
